// File: rtl/mips_pipeline_hazard_control_pkg.sv
// Shared pipeline definitions for the hazard controller and its mul/div tracker.
package mips_pipeline_hazard_control_pkg;

  // Register index type, matching the register-file typedefs.
  localparam int unsigned REG_IDX_W = 5;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // $zero is hard-wired and never creates a dependency.
  localparam reg_idx_t REG_ZERO = REG_IDX_W'(0);

  // Wide enough for the largest legal mul/div latency (63).
  localparam int unsigned BUSY_CNT_W = 6;

  // Mul/div occupancy FSM encoding.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mips_pipeline_muldiv_tracker.sv
// Tracks occupancy of the multi-cycle mul/div unit after a start pulse.
module mips_pipeline_muldiv_tracker
  import mips_pipeline_hazard_control_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic busy
);

  md_state_e             state_q;
  md_state_e             state_d;
  logic [BUSY_CNT_W-1:0] count_q;
  logic [BUSY_CNT_W-1:0] count_d;

  // State and down-counter registers, synchronously cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: a start arms the counter; BUSY lasts until the counter reaches zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          count_d = BUSY_CNT_W'(MULDIV_LATENCY - 1);
        end
      end
      BUSY: begin
        if (count_q == '0) begin
          state_d = IDLE;
        end else begin
          count_d = count_q - BUSY_CNT_W'(1);
        end
      end
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/mips_pipeline_hazard_control.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, mul/div occupancy, EX redirects.
module mips_pipeline_hazard_control
  import mips_pipeline_hazard_control_pkg::*;
#(
  parameter int unsigned MULDIV_LATENCY = 32,
  parameter int unsigned COUNT_W        = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  reg_idx_t           id_rs,
  input  reg_idx_t           id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_is_muldiv,
  input  logic               id_reads_hilo,
  input  logic               ex_mem_read,
  input  reg_idx_t           ex_rd,
  input  logic               ex_redirect,
  output logic               pc_enable,
  output logic               ifid_enable,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               muldiv_start,
  output logic               muldiv_busy,
  output logic [COUNT_W-1:0] stall_count
);

  logic load_use;
  logic md_hazard;
  logic stall;

  // Hazard detection; a redirect squashes the ID instruction so it cannot stall.
  always_comb begin
    load_use  = ex_mem_read && (ex_rd != REG_ZERO) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    md_hazard = muldiv_busy && (id_is_muldiv || id_reads_hilo);
    stall     = (load_use || md_hazard) && !ex_redirect;
  end

  // Pipeline enables/clears by priority: reset, redirect, stall, normal flow.
  always_comb begin
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    muldiv_start = 1'b0;
    if (reset) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_enable   = 1'b0;
      ifid_enable = 1'b0;
      idex_flush  = 1'b1;
    end else begin
      muldiv_start = id_is_muldiv && !muldiv_busy;
    end
  end

  mips_pipeline_muldiv_tracker #(
    .MULDIV_LATENCY(MULDIV_LATENCY)
  ) u_muldiv_tracker (
    .clock(clock),
    .reset(reset),
    .start(muldiv_start),
    .busy (muldiv_busy)
  );

  // Saturating count of stall cycles; redirect cycles never stall so are excluded.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {COUNT_W{1'b1}})) begin
      stall_count <= stall_count + COUNT_W'(1);
    end
  end

endmodule
